// File: rtl/cim_job_sequencer.sv
// Command sequencer for the 8x8 compute-in-memory GeMM macro: weight LOAD, and COMPUTE (clear, accumulate, drain).
// Optional macro CIM_SEQ_RELU_EN clamps negative drained results to zero.
module cim_job_sequencer #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              cim_cs,
  output logic              cim_write,
  output logic              cim_en,
  output logic              cim_partial_sum,
  output logic              cim_reset_output,
  output logic [3:0]        cim_output_reg,
  output logic [31:0]       cim_address,
  output logic [31:0]       cim_input_data,
  input  logic [31:0]       cim_output
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_ACC, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  i_q, i_d;
  logic [2:0]        r_q, r_d;
  logic              done_q, done_d;
  logic              last_word;
  logic [31:0]       base_addr;
  logic [31:0]       result;

  // len is never 0 in LOAD/ACC, so len-1 is the index of the final word.
  assign last_word = (i_q == len_q - LEN_W'(1));
  assign base_addr = 32'(addr_q);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

`ifdef CIM_SEQ_RELU_EN
  assign result = cim_output[31] ? 32'd0 : cim_output;
`else
  assign result = cim_output;
`endif

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    i_d              = i_q;
    r_d              = r_q;
    done_d           = 1'b0;
    cmd_ready        = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    out_data         = 32'd0;
    out_last         = 1'b0;
    cim_cs           = 1'b0;
    cim_write        = 1'b0;
    cim_en           = 1'b0;
    cim_partial_sum  = 1'b0;
    cim_reset_output = 1'b0;
    cim_output_reg   = 4'd0;
    cim_address      = 32'd0;
    cim_input_data   = 32'd0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          i_d    = '0;
          if (cmd_op)
            state_d = S_CLEAR;
          else if (cmd_len == '0)
            done_d = 1'b1;
          else
            state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready       = 1'b1;
        cim_cs         = in_valid;
        cim_write      = in_valid;
        cim_address    = base_addr + (32'(i_q) << 2);
        cim_input_data = in_data;
        if (in_valid) begin
          i_d = i_q + LEN_W'(1);
          if (last_word) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        cim_cs           = 1'b1;
        cim_en           = 1'b1;
        cim_reset_output = 1'b1;
        r_d              = 3'd0;
        state_d          = (len_q == '0) ? S_DRAIN : S_ACC;
      end
      S_ACC: begin
        in_ready        = 1'b1;
        cim_en          = 1'b1;
        cim_cs          = in_valid;
        cim_partial_sum = in_valid;
        cim_address     = base_addr + (32'(i_q) << 3);
        cim_input_data  = in_data;
        if (in_valid) begin
          i_d = i_q + LEN_W'(1);
          if (last_word) begin
            state_d = S_DRAIN;
            r_d     = 3'd0;
          end
        end
      end
      S_DRAIN: begin
        cim_en         = 1'b1;
        cim_output_reg = {1'b0, r_q};
        out_valid      = 1'b1;
        out_data       = result;
        out_last       = (r_q == 3'd7);
        if (out_ready) begin
          r_d = r_q + 3'd1;
          if (r_q == 3'd7) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      i_q     <= '0;
      r_q     <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      i_q     <= i_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cim_job_sequencer.sv
// Scoreboard bench for cim_job_sequencer with a behavioural model of the 8x8 CIM macro.
module tb_cim_job_sequencer;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, done;
  logic        cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output;
  logic [3:0]  cim_output_reg;
  logic [31:0] cim_address, cim_input_data, cim_output;

  cim_job_sequencer #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done),
    .cim_cs(cim_cs), .cim_write(cim_write), .cim_en(cim_en),
    .cim_partial_sum(cim_partial_sum), .cim_reset_output(cim_reset_output),
    .cim_output_reg(cim_output_reg), .cim_address(cim_address),
    .cim_input_data(cim_input_data), .cim_output(cim_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CIM_SEQ_RELU_EN
  localparam logic [31:0] NEG_RES = 32'h0000_0000;
`else
  localparam logic [31:0] NEG_RES = 32'hFFFF_FFFB;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  oreg;
  } out_t;

  int checks = 0;
  int passes = 0;
  int wr_count = 0;
  out_t        exp_out[$];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_acc[$];
  logic [31:0] in_q[$];
  bit          stall = 1'b0;

  logic [7:0]  mem [0:1023];
  logic [31:0] acc [0:7];

  assign cim_output = cim_en ? acc[cim_output_reg[2:0]] : 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Macro model plus write/accumulate monitor, sampled mid-cycle.
  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    for (int k = 0; k < 8; k++) acc[k] = 32'd0;
    forever begin
      @(negedge clk);
      if (cim_cs && cim_write) begin
        wr_count++;
        if (exp_wr.size() == 0) begin
          checks++;
          $display("FAIL wr_unexpected: got address %h, expected no write", cim_address);
        end else chk("wr_addr", cim_address, exp_wr.pop_front());
        for (int b = 0; b < 4; b++)
          mem[(cim_address + b) & 32'h3FF] = cim_input_data[31-8*b -: 8];
      end
      if (cim_cs && cim_en && cim_reset_output)
        for (int k = 0; k < 8; k++) acc[k] = 32'd0;
      if (cim_cs && cim_en && cim_partial_sum && !cim_write) begin
        if (exp_acc.size() == 0) begin
          checks++;
          $display("FAIL acc_unexpected: got address %h, expected no accumulate", cim_address);
        end else chk("acc_addr", cim_address, exp_acc.pop_front());
        for (int k = 0; k < 8; k++) begin
          int s;
          logic [5:0] adc;
          s = 0;
          for (int j = 0; j < 8; j++)
            s += int'(mem[k*128 + ((int'(cim_address[6:0]) + j) & 127)]) * int'(cim_input_data[4*j +: 4]);
          adc = s[14:9];
          acc[k] = acc[k] + {{26{adc[5]}}, adc};
        end
      end
    end
  end

  // Result stream monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: got %h, expected no output", out_data);
        end else begin
          out_t e;
          e = exp_out.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          chk("out_reg", cim_output_reg, e.oreg);
        end
      end
    end
  end

  // Input stream driver fed from in_q; optional alternate-cycle stalls.
  initial begin
    bit hs;
    bit toggle;
    toggle = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) void'(in_q.pop_front());
      toggle = ~toggle;
      if (in_q.size() > 0 && !(stall && toggle)) begin
        in_valid = 1'b1;
        in_data  = in_q[0];
      end else begin
        in_valid = 1'b0;
      end
    end
  end

  task automatic push_drain(input logic [31:0] v0, input logic [31:0] v3);
    for (int r = 0; r < 8; r++) begin
      out_t e;
      e.data = (r == 0) ? v0 : (r == 3) ? v3 : 32'd0;
      e.last = (r == 7);
      e.oreg = 4'(r);
      exp_out.push_back(e);
    end
  endtask

  task automatic run_cmd(input bit op, input logic [31:0] addr, input logic [15:0] len,
                         input int exp_lat, input string name);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    chk({name, "_cmd_ready"}, cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      $display("FAIL %s_timeout: got no done, expected done within 400 cycles", name);
    end else if (exp_lat >= 0) begin
      chk({name, "_latency"}, n, exp_lat);
    end
    $display("cmd %s op=%0d addr=%h len=%0d done_after=%0d", name, op, addr, len, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before 300us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = 32'd0; cmd_len = 16'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", {cmd_ready, busy, in_ready, out_valid, out_last, done}, 6'b100000);
    chk("reset_cim", {cim_cs, cim_write, cim_en, cim_partial_sum, cim_reset_output, cim_output_reg}, 9'd0);
    chk("reset_bus", {cim_address, out_data}, 64'd0);
    chk("reset_data", cim_input_data, 32'd0);
    @(posedge clk); #1;
    chk("reset_no_write", wr_count, 0);

    // Weight load of bank 0 row 0
    exp_wr.push_back(32'd0); exp_wr.push_back(32'd4);
    in_q.push_back(32'h7F7F7F7F); in_q.push_back(32'h7F7F7F7F);
    run_cmd(1'b0, 32'd0, 16'd2, 2, "load0");
    for (int b = 0; b < 8; b++) chk("load0_byte", mem[b], 8'h7F);

    // Single compute row
    in_q.push_back(32'hFFFFFFFF);
    exp_acc.push_back(32'd0);
    push_drain(32'h0000001D, 32'd0);
    run_cmd(1'b1, 32'd0, 16'd1, 10, "compute1");

    // Two rows with input stalls
    exp_wr.push_back(32'd8); exp_wr.push_back(32'd12);
    in_q.push_back(32'h7F7F7F7F); in_q.push_back(32'h7F7F7F7F);
    run_cmd(1'b0, 32'd8, 16'd2, 2, "load8");
    stall = 1'b1;
    in_q.push_back(32'hFFFFFFFF); in_q.push_back(32'hFFFFFFFF);
    exp_acc.push_back(32'd0); exp_acc.push_back(32'd8);
    push_drain(32'h0000003A, 32'd0);
    run_cmd(1'b1, 32'd0, 16'd2, -1, "compute_stall");
    stall = 1'b0;

    run_cmd(1'b0, 32'h40, 16'd0, 0, "load_len0");

    // Negative results and address wrap
    exp_wr.push_back(32'd0); exp_wr.push_back(32'd4);
    in_q.push_back(32'hFFFFFFFF); in_q.push_back(32'hFFFFFFFF);
    run_cmd(1'b0, 32'd0, 16'd2, 2, "load_neg");
    exp_wr.push_back(32'hFFFFFFFC); exp_wr.push_back(32'd0);
    in_q.push_back(32'hFFFFFFFF); in_q.push_back(32'hFFFFFFFF);
    run_cmd(1'b0, 32'hFFFFFFFC, 16'd2, 2, "load_wrap");
    in_q.push_back(32'hFFFFFFFF);
    exp_acc.push_back(32'd0);
    push_drain(NEG_RES, 32'd0);
    run_cmd(1'b1, 32'd0, 16'd1, 10, "compute_neg");

    // Bank 3 load, then drain back-pressure at r=3
    exp_wr.push_back(32'd384); exp_wr.push_back(32'd388);
    in_q.push_back(32'h7F7F7F7F); in_q.push_back(32'h7F7F7F7F);
    run_cmd(1'b0, 32'd384, 16'd2, 2, "load_bank3");
    in_q.push_back(32'hFFFFFFFF);
    exp_acc.push_back(32'd0);
    push_drain(NEG_RES, 32'h0000001D);
    fork
      run_cmd(1'b1, 32'd0, 16'd1, 15, "compute_bp");
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!(out_valid && cim_output_reg == 4'd2) && w < 100);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_data", out_data, 32'h0000001D);
          chk("bp_state", {out_valid, out_last, cim_output_reg}, 6'b10_0011);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join

    // Reset during ACC, then a clean compute
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 32'd0; cmd_len = 16'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midacc_busy", {busy, in_ready, cim_en}, 3'b111);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midacc_idle", {busy, cmd_ready, in_ready, cim_en, done}, 5'b01000);
    $display("cmd reset_mid_acc op=1 addr=00000000 len=2 aborted");
    in_q.push_back(32'hFFFFFFFF);
    exp_acc.push_back(32'd0);
    push_drain(NEG_RES, 32'h0000001D);
    run_cmd(1'b1, 32'd0, 16'd1, 10, "compute_after_rst");

    repeat (3) @(posedge clk);
    chk("out_queue_empty", exp_out.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("acc_queue_empty", exp_acc.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
